// File: rtl/cordic_pkg.sv
// Shared constants, register map and sequencer states for the CORDIC
// APB register front end.
package cordic_pkg;

    localparam int N          = 32;
    localparam int NUM_INVTAN = 32;

    localparam int unsigned CTRL_OFF    = 'h000;
    localparam int unsigned STATUS_OFF  = 'h004;
    localparam int unsigned X_IN_OFF    = 'h008;
    localparam int unsigned Y_IN_OFF    = 'h00C;
    localparam int unsigned Z_IN_OFF    = 'h010;
    localparam int unsigned FRAC_OFF    = 'h014;
    localparam int unsigned SCALE_OFF   = 'h018;
    localparam int unsigned ONE_OFF     = 'h01C;
    localparam int unsigned X_OUT_OFF   = 'h020;
    localparam int unsigned Y_OUT_OFF   = 'h024;
    localparam int unsigned Z_OUT_OFF   = 'h028;
    localparam int unsigned INVTAN_BASE = 'h080;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

endpackage

// File: rtl/cordic_invtan_bank.sv
// Arctangent table: 32 words written/read by index, frozen while the
// core is iterating, exposed to the core as one flat bus.
module cordic_invtan_bank
    import cordic_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic                      busy,
    input  logic [4:0]                idx,
    input  logic [N-1:0]              wdata,
    output logic [N-1:0]              rdata,
    output logic [NUM_INVTAN*N-1:0]   invtan
);

    logic [N-1:0] tab [NUM_INVTAN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INVTAN; i++) begin
                tab[i] <= '0;
            end
        end else if (we && !busy) begin
            tab[idx] <= wdata;
        end
    end

    assign rdata = tab[idx];

    always_comb begin
        invtan = '0;
        for (int i = 0; i < NUM_INVTAN; i++) begin
            invtan[i*N +: N] = tab[i];
        end
    end

endmodule

// File: rtl/cordic_apb_regs.sv
// APB3 register bank and run sequencer feeding the iterative CORDIC core:
// operands, constants, start pulse, result capture, watchdog and irq.
module cordic_apb_regs
    import cordic_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_W-1:0]       paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [31:0]             core_x,
    output logic [31:0]             core_y,
    output logic [31:0]             core_z,
    output logic                    core_mode,
    output logic                    core_start,
    output logic [4:0]              core_xyfracbase,
    output logic [4:0]              core_phasefracbase,
    output logic [31:0]             core_scale_factor,
    output logic [31:0]             core_xybaseone,
    output logic [NUM_INVTAN*N-1:0] core_invtan,
    input  logic [31:0]             core_x_n,
    input  logic [31:0]             core_y_n,
    input  logic [31:0]             core_z_n,
    input  logic                    core_done,
    output logic                    irq
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t state, state_d;
    logic [WD_W-1:0] wd;
    logic mode, irq_en, done, err;
    logic done_d, err_d, irq_en_d;
    logic [31:0] x_in, y_in, z_in, scale, xy_one;
    logic [31:0] x_out, y_out, z_out;
    logic [4:0] xy_fb, ph_fb;
    logic [31:0] inv_rdata;

    logic acc, wr, busy;
    logic hit_ctrl, hit_status, hit_x, hit_y, hit_z, hit_frac;
    logic hit_scale, hit_one, hit_xo, hit_yo, hit_zo, hit_inv;
    logic cfg_hit, ro_hit, mapped, mode_clash;
    logic start_req, capture, timeout;

    assign acc  = psel && penable;
    assign wr   = acc && pwrite;
    assign busy = (state != IDLE);

    assign hit_ctrl   = (paddr == ADDR_W'(CTRL_OFF));
    assign hit_status = (paddr == ADDR_W'(STATUS_OFF));
    assign hit_x      = (paddr == ADDR_W'(X_IN_OFF));
    assign hit_y      = (paddr == ADDR_W'(Y_IN_OFF));
    assign hit_z      = (paddr == ADDR_W'(Z_IN_OFF));
    assign hit_frac   = (paddr == ADDR_W'(FRAC_OFF));
    assign hit_scale  = (paddr == ADDR_W'(SCALE_OFF));
    assign hit_one    = (paddr == ADDR_W'(ONE_OFF));
    assign hit_xo     = (paddr == ADDR_W'(X_OUT_OFF));
    assign hit_yo     = (paddr == ADDR_W'(Y_OUT_OFF));
    assign hit_zo     = (paddr == ADDR_W'(Z_OUT_OFF));
    assign hit_inv    = (paddr[ADDR_W-1:7] == (ADDR_W-7)'(INVTAN_BASE >> 7))
                     && (paddr[1:0] == 2'b00);

    assign cfg_hit = hit_x || hit_y || hit_z || hit_frac
                  || hit_scale || hit_one || hit_inv;
    assign ro_hit  = hit_xo || hit_yo || hit_zo;
    assign mapped  = hit_ctrl || hit_status || cfg_hit || ro_hit;

    // Rewriting MODE with its current value is harmless, so only a change errors.
    assign mode_clash = hit_ctrl && (pwdata[CTRL_MODE] != mode);

    assign pready  = 1'b1;
    assign pslverr = acc && (!mapped || (pwrite && (ro_hit
                  || (busy && (cfg_hit || mode_clash)))));

    assign start_req = wr && hit_ctrl && pwdata[CTRL_START];
    assign capture   = (state == RUN) && core_done;
    assign timeout   = (state == RUN) && !core_done && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start_req) state_d = START;
            START:   state_d = RUN;
            RUN:     if (capture || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == START);
    end

    always_comb begin
        done_d   = done;
        err_d    = err;
        irq_en_d = irq_en;
        if (wr && hit_status && pwdata[ST_DONE]) done_d = 1'b0;
        if (wr && hit_status && pwdata[ST_ERR])  err_d  = 1'b0;
        if (capture) done_d = 1'b1;
        if (timeout || (start_req && busy)) err_d = 1'b1;
        if (wr && hit_ctrl) irq_en_d = pwdata[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode   <= 1'b0;
            irq_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            irq    <= 1'b0;
            x_in   <= '0;
            y_in   <= '0;
            z_in   <= '0;
            xy_fb  <= '0;
            ph_fb  <= '0;
            scale  <= '0;
            xy_one <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
            wd     <= '0;
        end else begin
            if (wr && hit_ctrl && !busy) mode <= pwdata[CTRL_MODE];
            irq_en <= irq_en_d;
            done   <= done_d;
            err    <= err_d;
            irq    <= (done_d || err_d) && irq_en_d;
            if (wr && cfg_hit && !busy) begin
                unique case (1'b1)
                    hit_x:     x_in   <= pwdata;
                    hit_y:     y_in   <= pwdata;
                    hit_z:     z_in   <= pwdata;
                    hit_scale: scale  <= pwdata;
                    hit_one:   xy_one <= pwdata;
                    hit_frac: begin
                        xy_fb <= pwdata[4:0];
                        ph_fb <= pwdata[12:8];
                    end
                    default: ;
                endcase
            end
            if (capture) begin
                x_out <= core_x_n;
                y_out <= core_y_n;
                z_out <= core_z_n;
            end
            if (state == START) begin
                wd <= '0;
            end else if (state == RUN) begin
                wd <= wd + 1'b1;
            end
        end
    end

    cordic_invtan_bank u_invtan (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr && hit_inv),
        .busy   (busy),
        .idx    (paddr[6:2]),
        .wdata  (pwdata),
        .rdata  (inv_rdata),
        .invtan (core_invtan)
    );

    always_comb begin
        prdata = '0;
        if (acc && !pwrite) begin
            unique case (1'b1)
                hit_ctrl: begin
                    prdata[CTRL_MODE]   = mode;
                    prdata[CTRL_IRQ_EN] = irq_en;
                end
                hit_status: begin
                    prdata[ST_BUSY] = busy;
                    prdata[ST_DONE] = done;
                    prdata[ST_ERR]  = err;
                end
                hit_x:     prdata = x_in;
                hit_y:     prdata = y_in;
                hit_z:     prdata = z_in;
                hit_frac:  prdata = {19'b0, ph_fb, 3'b0, xy_fb};
                hit_scale: prdata = scale;
                hit_one:   prdata = xy_one;
                hit_xo:    prdata = x_out;
                hit_yo:    prdata = y_out;
                hit_zo:    prdata = z_out;
                hit_inv:   prdata = inv_rdata;
                default:   prdata = '0;
            endcase
        end
    end

    assign core_x             = x_in;
    assign core_y             = y_in;
    assign core_z             = z_in;
    assign core_mode          = mode;
    assign core_xyfracbase    = xy_fb;
    assign core_phasefracbase = ph_fb;
    assign core_scale_factor  = scale;
    assign core_xybaseone     = xy_one;

endmodule
